riscv_core_dpath_vregfile_clr: RTL and testbench
================================================

# riscv_core_dpath_vregfile_clr

Parametrised vector register file for the 7-stage RISC-V core's vector datapath. It holds NREGS vectors of VLEN elements and serves two LANES-wide read groups and one LANES-wide masked write group per cycle, with element indices wrapping modulo VLEN. A built-in clear sequencer zeroes a whole vector register over VLEN/LANES cycles through a valid/ready request. It sits between vector decode (operand read) and vector writeback, replacing the fixed 32x64x4 file.

## Interface
- NREGS, 32, number of vector registers (power of two)
- VLEN, 64, elements per vector (power of two)
- LANES, 4, elements per read/write group (power of two, divides VLEN)
- DW, 32, element width in bits
- AW = clog2(NREGS), IW = clog2(VLEN): derived, not overridable

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- raddr0 / raddr1  in  AW  read register address, ports 0/1
- ridx0 / ridx1  in  IW  read start element, ports 0/1
- rdata0 / rdata1  out  LANES*DW  lane k = element (ridx+k) mod VLEN, lane 0 in bits [DW-1:0]
- wen_p  in  1  write enable
- waddr_p  in  AW  write register address
- widx_p  in  IW  write start element
- wmask_p  in  LANES  per-lane write enable
- wdata_p  in  LANES*DW  write data, same lane packing
- clr_val  in  1  clear request valid
- clr_addr  in  AW  register to clear
- clr_rdy  out  1  clear request ready
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse: clear completed

## Operation
- Reads are combinational on raddr/ridx; no read enable.
- Write: at rising edge, if wen_p, element (widx_p+k) mod VLEN of waddr_p <= lane k of wdata_p for every k with wmask_p[k]=1; unmasked lanes unchanged. wmask_p=0 with wen_p=1 is a legal no-op.
- All index arithmetic is IW bits and wraps: widx_p=VLEN-2, LANES=4 writes elements VLEN-2, VLEN-1, 0, 1.
- Clear FSM states: IDLE, CLEAR.
  - IDLE: clr_rdy=1, clr_busy=0. clr_val&clr_rdy at an edge -> capture clr_addr, group counter <= 0, go CLEAR.
  - CLEAR: clr_rdy=0, clr_busy=1. Each edge zeroes elements counter*LANES .. counter*LANES+LANES-1 of the captured register, counter++. At the edge writing group VLEN/LANES-1 -> IDLE, clr_done=1 for the next cycle only.
- Same-cycle conflict between clear and wen_p on the same element: wen_p data wins. Other elements of that group are still zeroed.
- Reads of a register being cleared return current storage (mixed old/zero); no stall is generated here, hazard control is the caller's job.
- A new clear accepted in the clr_done cycle is legal (back-to-back).
- Storage is not reset. reset_n=0: FSM -> IDLE, counter -> 0, clr_done=0, clr_busy=0, clr_rdy=1 from the cycle after the reset edge. Reset mid-clear abandons the clear: no clr_done pulse, partially zeroed register left as-is.

## Timing
- Write latency 1: data written at edge N is visible on rdata from cycle N+1 (without bypass).
- Clear accepted at edge N: group j zeroed at edge N+1+j; clr_busy high for cycles N+1 .. N+VLEN/LANES; clr_done high in cycle N+VLEN/LANES+1.
- clr_rdy, clr_busy are decoded from the registered state; clr_done is registered.

## Configuration
- RISCV_VRF_BYPASS_EN defined: write-first forwarding. Read lane k returns wdata_p lane j when wen_p, wmask_p[j], waddr_p==raddr and element indices match in the same cycle. Otherwise, the lane returns zero when the active clear group covers that element and no such write is present. Otherwise, it returns storage.
- Undefined: reads always return storage; same-cycle writes/clears are visible next cycle.

## Structure
- Shared package riscv_vrf_pkg: FSM state encoding (IDLE=0, CLEAR=1), a clog2 function, and the lane pack/unpack index helpers.
- One sub-module: riscv_core_dpath_vregfile_clr_fsm (state, group counter, captured address, handshake outputs, clear write enable/index). Storage and read muxing stay in the top.

## Test plan
- Reset, then wen_p=1, waddr_p=3, widx_p=8, wmask_p=4'b1111, wdata_p={D,C,B,A} -> next cycle raddr0=3, ridx0=8 reads lanes A,B,C,D.
- Wrap: write reg 5 at widx_p=62 with {4,3,2,1} -> read ridx1=62 gives 1,2,3,4; read ridx1=0 gives 3,4 in lanes 0-1.
- Mask: preload reg 7 elems 0-3 = 0xFF; write wmask_p=4'b0101 data {9,8,7,6} -> elements read 6,0xFF,8,0xFF.
- Clear reg 2 (all preloaded nonzero) at edge N -> clr_rdy=0 and clr_busy=1 for cycles N+1..N+16 (VLEN=64, LANES=4), clr_done=1 only in cycle N+17, all 64 elements read 0, reg 3 untouched.
- Conflict: during clear of reg 2, write 0x55 to element 4 in the cycle group 1 is cleared -> element 4 = 0x55, elements 5-7 = 0.
- Reset asserted at cycle 5 of a clear -> no clr_done, clr_rdy=1 next cycle, groups 0-3 zero, groups 4-15 unchanged. With RISCV_VRF_BYPASS_EN, a same-cycle write+read to reg 1 elem 0 returns the new data combinationally.

Source files
------------

// File: rtl/riscv_vrf_pkg.sv
// riscv_vrf_pkg: clear FSM state encoding plus clog2 and lane packing helpers shared by the vector register file
package riscv_vrf_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lane_lo(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/riscv_core_dpath_vregfile_clr_fsm.sv
// riscv_core_dpath_vregfile_clr_fsm: clear sequencer zeroing one vector register a lane group per cycle
module riscv_core_dpath_vregfile_clr_fsm
  import riscv_vrf_pkg::*;
#(
  parameter int VLEN  = 64,
  parameter int LANES = 4,
  parameter int AW    = 5,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_val,
  input  logic [AW-1:0] clr_addr,
  output logic          clr_rdy,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_waddr,
  output logic [IW-1:0] clr_idx
);
  logic [0:0] state;
  logic       last;
  assign clr_rdy  = state == ST_IDLE;
  assign clr_busy = state == ST_CLEAR;
  assign clr_we   = clr_busy && reset_n;
  assign last     = clr_idx == IW'(VLEN - LANES);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      clr_idx  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= clr_busy && last;
      state    <= clr_busy ? (last ? ST_IDLE : ST_CLEAR) : (clr_val ? ST_CLEAR : ST_IDLE);
      clr_idx  <= clr_busy ? clr_idx + IW'(LANES) : '0;
      if (clr_rdy && clr_val) clr_waddr <= clr_addr;
    end
  end
endmodule

// File: rtl/riscv_core_dpath_vregfile_clr.sv
// riscv_core_dpath_vregfile_clr: 2R/1W lane-group vector register file with clear sequencer, optional RISCV_VRF_BYPASS_EN forwarding
module riscv_core_dpath_vregfile_clr
  import riscv_vrf_pkg::*;
#(
  parameter  int NREGS = 32,
  parameter  int VLEN  = 64,
  parameter  int LANES = 4,
  parameter  int DW    = 32,
  localparam int AW    = clog2(NREGS),
  localparam int IW    = clog2(VLEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [AW-1:0]       raddr0,
  input  logic [IW-1:0]       ridx0,
  output logic [LANES*DW-1:0] rdata0,
  input  logic [AW-1:0]       raddr1,
  input  logic [IW-1:0]       ridx1,
  output logic [LANES*DW-1:0] rdata1,
  input  logic                wen_p,
  input  logic [AW-1:0]       waddr_p,
  input  logic [IW-1:0]       widx_p,
  input  logic [LANES-1:0]    wmask_p,
  input  logic [LANES*DW-1:0] wdata_p,
  input  logic                clr_val,
  input  logic [AW-1:0]       clr_addr,
  output logic                clr_rdy,
  output logic                clr_busy,
  output logic                clr_done
);
  logic [DW-1:0] mem [NREGS][VLEN];
  logic          clr_we;
  logic [AW-1:0] clr_waddr;
  logic [IW-1:0] clr_idx;
  riscv_core_dpath_vregfile_clr_fsm #(.VLEN(VLEN), .LANES(LANES), .AW(AW), .IW(IW)) u_fsm (
    .clk(clk), .reset_n(reset_n), .clr_val(clr_val), .clr_addr(clr_addr),
    .clr_rdy(clr_rdy), .clr_busy(clr_busy), .clr_done(clr_done),
    .clr_we(clr_we), .clr_waddr(clr_waddr), .clr_idx(clr_idx)
  );
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (clr_we) mem[clr_waddr][clr_idx + IW'(k)] <= '0;
      if (wen_p && wmask_p[k]) mem[waddr_p][widx_p + IW'(k)] <= wdata_p[lane_lo(k, DW) +: DW];
    end
  end
`ifdef RISCV_VRF_BYPASS_EN
  localparam logic [IW-1:0] GMASK = ~IW'(LANES - 1);
`endif
  function automatic logic [DW-1:0] rd_elem(input logic [AW-1:0] a, input logic [IW-1:0] e);
    logic [DW-1:0] d;
    d = mem[a][e];
`ifdef RISCV_VRF_BYPASS_EN
    d = (clr_we && clr_waddr == a && (e & GMASK) == clr_idx) ? '0 : d;
    for (int j = 0; j < LANES; j++)
      d = (wen_p && wmask_p[j] && waddr_p == a && widx_p + IW'(j) == e) ? wdata_p[lane_lo(j, DW) +: DW] : d;
`endif
    return d;
  endfunction
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    for (int k = 0; k < LANES; k++) begin
      rdata0[lane_lo(k, DW) +: DW] = rd_elem(raddr0, ridx0 + IW'(k));
      rdata1[lane_lo(k, DW) +: DW] = rd_elem(raddr1, ridx1 + IW'(k));
    end
  end
endmodule

// File: tb/tb_riscv_core_dpath_vregfile_clr.sv
// tb_riscv_core_dpath_vregfile_clr: directed self-checking bench for the vector register file
module tb_riscv_core_dpath_vregfile_clr;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [4:0]   raddr0 = '0, raddr1 = '0, waddr_p = '0, clr_addr = '0;
  logic [5:0]   ridx0 = '0, ridx1 = '0, widx_p = '0;
  logic [127:0] rdata0, rdata1, wdata_p = '0, d;
  logic         wen_p = 1'b0, clr_val = 1'b0;
  logic [3:0]   wmask_p = '0;
  logic         clr_rdy, clr_busy, clr_done;
  int           n_cmp = 0, n_err = 0;
  riscv_core_dpath_vregfile_clr dut (
    .clk(clk), .reset_n(reset_n),
    .raddr0(raddr0), .ridx0(ridx0), .rdata0(rdata0),
    .raddr1(raddr1), .ridx1(ridx1), .rdata1(rdata1),
    .wen_p(wen_p), .waddr_p(waddr_p), .widx_p(widx_p), .wmask_p(wmask_p), .wdata_p(wdata_p),
    .clr_val(clr_val), .clr_addr(clr_addr),
    .clr_rdy(clr_rdy), .clr_busy(clr_busy), .clr_done(clr_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [5:0] idx, input logic [3:0] m, input logic [127:0] v);
    wen_p = 1'b1; waddr_p = a; widx_p = idx; wmask_p = m; wdata_p = v;
    tick;
    wen_p = 1'b0; wmask_p = '0;
  endtask
  task automatic rd0(input logic [4:0] a, input logic [5:0] idx, output logic [127:0] v);
    raddr0 = a; ridx0 = idx;
    #1;
    v = rdata0;
  endtask
  function automatic logic [127:0] pack4(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction
  task automatic preload(input logic [4:0] a, input logic [31:0] base);
    for (int g = 0; g < 16; g++) wr(a, 6'(g * 4), 4'hf, pack4(base + 32'(g * 4)));
  endtask
  initial begin
    tick; tick;
    reset_n = 1'b1;
    check("rst_rdy", 128'(clr_rdy), 128'd1);
    check("rst_busy", 128'(clr_busy), 128'd0);
    check("rst_done", 128'(clr_done), 128'd0);
    wr(5'd3, 6'd8, 4'hf, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
    rd0(5'd3, 6'd8, d);
    check("basic_wr", d, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
    wr(5'd5, 6'd62, 4'hf, {32'd4, 32'd3, 32'd2, 32'd1});
    raddr1 = 5'd5; ridx1 = 6'd62;
    #1;
    check("wrap_62", rdata1, {32'd4, 32'd3, 32'd2, 32'd1});
    ridx1 = 6'd0;
    #1;
    check("wrap_0", 128'(rdata1[63:0]), 128'({32'd4, 32'd3}));
    wr(5'd7, 6'd0, 4'hf, {4{32'hFF}});
    wr(5'd7, 6'd0, 4'b0101, {32'd9, 32'd8, 32'd7, 32'd6});
    rd0(5'd7, 6'd0, d);
    check("mask", d, {32'hFF, 32'd8, 32'hFF, 32'd6});
    wr(5'd7, 6'd0, 4'b0000, {4{32'h1234}});
    rd0(5'd7, 6'd0, d);
    check("mask_none", d, {32'hFF, 32'd8, 32'hFF, 32'd6});
    preload(5'd2, 32'h200);
    preload(5'd3, 32'h300);
    clr_val = 1'b1; clr_addr = 5'd2;
    tick;
    clr_val = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("clr_busy_c%0d", i), 128'(clr_busy), 128'd1);
      check($sformatf("clr_rdy_c%0d", i), 128'(clr_rdy), 128'd0);
      check($sformatf("clr_done_c%0d", i), 128'(clr_done), 128'd0);
      if (i == 2) begin
        wen_p = 1'b1; waddr_p = 5'd2; widx_p = 6'd4; wmask_p = 4'b0001; wdata_p = 128'h55;
      end
      tick;
      wen_p = 1'b0; wmask_p = '0;
    end
    check("clr_done_pulse", 128'(clr_done), 128'd1);
    check("clr_idle_busy", 128'(clr_busy), 128'd0);
    check("clr_idle_rdy", 128'(clr_rdy), 128'd1);
    tick;
    check("clr_done_drop", 128'(clr_done), 128'd0);
    for (int g = 0; g < 16; g++) begin
      rd0(5'd2, 6'(g * 4), d);
      check($sformatf("clr_r2_g%0d", g), d, g == 1 ? 128'h55 : 128'd0);
      rd0(5'd3, 6'(g * 4), d);
      check($sformatf("keep_r3_g%0d", g), d, pack4(32'h300 + 32'(g * 4)));
    end
    preload(5'd2, 32'hA00);
    clr_val = 1'b1; clr_addr = 5'd2;
    tick;
    clr_val = 1'b0;
    tick; tick; tick; tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    check("abort_rdy", 128'(clr_rdy), 128'd1);
    check("abort_busy", 128'(clr_busy), 128'd0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("abort_done_c%0d", i), 128'(clr_done), 128'd0);
      tick;
    end
    for (int g = 0; g < 16; g++) begin
      rd0(5'd2, 6'(g * 4), d);
      check($sformatf("abort_g%0d", g), d, g < 4 ? 128'd0 : pack4(32'hA00 + 32'(g * 4)));
    end
    wr(5'd1, 6'd0, 4'hf, {4{32'h11}});
    wen_p = 1'b1; waddr_p = 5'd1; widx_p = 6'd0; wmask_p = 4'b0001; wdata_p = 128'h22;
    rd0(5'd1, 6'd0, d);
`ifdef RISCV_VRF_BYPASS_EN
    check("same_cycle_rd", d, {{3{32'h11}}, 32'h22});
`else
    check("same_cycle_rd", d, {4{32'h11}});
`endif
    tick;
    wen_p = 1'b0; wmask_p = '0;
    rd0(5'd1, 6'd0, d);
    check("next_cycle_rd", d, {{3{32'h11}}, 32'h22});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
